// File: rtl/sha256_msg_schedule.sv
// SHA-256 message-schedule generator: takes 16 serial message words per block and
// streams W0..W63 out through a single-register valid/ready output slot.
module sha256_msg_schedule #(
    parameter int ROUNDS = 64,
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              blk_start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [WORD_W-1:0] w_word,
    output logic [5:0]        w_idx,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DRAIN} state_t;

    state_t             state_r;
    state_t             state_s;
    logic [6:0]         t_r;
    logic [WORD_W-1:0]  win_r [16];
    logic               w_valid_r;
    logic [WORD_W-1:0]  w_word_r;
    logic [5:0]         w_idx_r;
    logic               busy_r;
    logic               done_r;

    logic               slot_free_s;
    logic               load_s;
    logic               start_s;
    logic               finish_s;
    logic               in_ready_s;
    logic [WORD_W-1:0]  load_word_s;
    logic [WORD_W-1:0]  expand_word_s;

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
    endfunction

    // win_r[15] is W[t-1] (newest), win_r[0] is W[t-16] (oldest)
    assign slot_free_s   = !w_valid_r || w_ready;
    assign expand_word_s = small_sigma1(win_r[14]) + win_r[9]
                         + small_sigma0(win_r[1]) + win_r[0];

    // Next-state, slot-load and handshake decode
    always_comb begin
        state_s     = state_r;
        load_s      = 1'b0;
        load_word_s = expand_word_s;
        in_ready_s  = 1'b0;
        start_s     = 1'b0;
        finish_s    = 1'b0;
        case (state_r)
            IDLE: begin
                // A start coinciding with the done pulse is deliberately dropped
                if (blk_start && !done_r) begin
                    start_s = 1'b1;
                    state_s = LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                in_ready_s = slot_free_s;
                if (in_valid && slot_free_s) begin
                    load_s      = 1'b1;
                    load_word_s = in_word;
                    if (t_r == 7'd15) begin
                        state_s = EXPAND;
                    end else begin
                        state_s = LOAD;
                    end
                end else begin
                    state_s = LOAD;
                end
            end
            EXPAND: begin
                if (slot_free_s) begin
                    load_s = 1'b1;
                    if (t_r == 7'(ROUNDS - 1)) begin
                        state_s = DRAIN;
                    end else begin
                        state_s = EXPAND;
                    end
                end else begin
                    state_s = EXPAND;
                end
            end
            DRAIN: begin
                if (w_valid_r && w_ready) begin
                    finish_s = 1'b1;
                    state_s  = IDLE;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state, word counter and status flags
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= IDLE;
            t_r     <= 7'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            done_r  <= finish_s;
            if (start_s) begin
                t_r <= 7'd0;
            end else if (load_s) begin
                t_r <= t_r + 7'd1;
            end else begin
                t_r <= t_r;
            end
            if (start_s) begin
                busy_r <= 1'b1;
            end else if (finish_s) begin
                busy_r <= 1'b0;
            end else begin
                busy_r <= busy_r;
            end
        end
    end

    // Output slot: load replaces contents, a bare handshake empties it
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            w_valid_r <= 1'b0;
            w_word_r  <= '0;
            w_idx_r   <= 6'd0;
        end else if (load_s) begin
            w_valid_r <= 1'b1;
            w_word_r  <= load_word_s;
            w_idx_r   <= t_r[5:0];
        end else if (w_valid_r && w_ready) begin
            w_valid_r <= 1'b0;
        end else begin
            w_valid_r <= w_valid_r;
        end
    end

    // 16-word history window, cleared per block so nothing leaks between blocks
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 16; i++) begin
                win_r[i] <= '0;
            end
        end else if (start_s) begin
            for (int i = 0; i < 16; i++) begin
                win_r[i] <= '0;
            end
        end else if (load_s) begin
            for (int i = 0; i < 15; i++) begin
                win_r[i] <= win_r[i + 1];
            end
            win_r[15] <= load_word_s;
        end else begin
            for (int i = 0; i < 16; i++) begin
                win_r[i] <= win_r[i];
            end
        end
    end

    assign in_ready = in_ready_s;
    assign w_valid  = w_valid_r;
    assign w_word   = w_word_r;
    assign w_idx    = w_idx_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Self-checking bench for sha256_msg_schedule: a reference schedule model feeds a
// scoreboard queue that is compared against every output handshake.
module tb_sha256_msg_schedule;

    logic        CLK = 1'b0;
    logic        RST;
    logic        blk_start;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_word;
    logic [5:0]  w_idx;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_w [64];
    logic [31:0] got_w [64];
    logic [37:0] exp_q [$];

    localparam logic [511:0] ABC = {32'h61626380, 448'h0, 32'h00000018};

    sha256_msg_schedule #(.ROUNDS(64), .WORD_W(32)) dut (
        .CLK(CLK), .RST(RST), .blk_start(blk_start),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
        .w_valid(w_valid), .w_ready(w_ready), .w_word(w_word), .w_idx(w_idx),
        .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ref_s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ref_s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic compute_sched(input logic [511:0] blk);
        for (int i = 0; i < 16; i++) exp_w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++)
            exp_w[i] = ref_s1(exp_w[i-2]) + exp_w[i-7] + ref_s0(exp_w[i-15]) + exp_w[i-16];
    endtask

    task automatic rand_block(output logic [511:0] b);
        for (int i = 0; i < 16; i++) b[511 - 32*i -: 32] = $urandom();
    endtask

    // Runs one block from blk_start; call at posedge+1. Returns at posedge+1 after done.
    task automatic run_block(input logic [511:0] blk, input int rdy_mode, input bit gap,
                             input int start_at, input int rst_at, input bit start_on_done,
                             output int nwords, output bit saw_done);
        int cyc = 0;
        int in_ptr = 0;
        int gap_cnt = 0;
        bit expect_done = 0;
        bit prev_stall = 0;
        bit fin = 0;
        bit start_pend = 0;
        bit rst_pend = 0;
        bit in_hs, out_hs;
        logic [31:0] prev_word = 32'h0;
        logic [5:0]  prev_idx = 6'd0;
        logic [31:0] mw;
        logic [37:0] e;
        nwords = 0;
        saw_done = 0;
        compute_sched(blk);
        exp_q.delete();
        for (int i = 0; i < 64; i++) got_w[i] = 32'h0;
        blk_start = 1'b1; in_valid = 1'b0; w_ready = 1'b1;
        @(posedge CLK); #1;
        blk_start = 1'b0;
        while (!fin) begin
            if (rst_pend) begin
                RST = 1'b1; in_valid = 1'b0; blk_start = 1'b0;
                #1;
                checks++;
                if (w_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0)
                    begin errors++; $display("FAIL rst_abort: w_valid=%b busy=%b done=%b in_ready=%b, required all 0", w_valid, busy, done, in_ready); end
                @(posedge CLK); #1;
                RST = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    #1;
                    checks++;
                    if (done !== 1'b0 || busy !== 1'b0 || w_valid !== 1'b0)
                        begin errors++; $display("FAIL post_rst: done=%b busy=%b w_valid=%b, required 0", done, busy, w_valid); end
                    @(posedge CLK); #1;
                end
                exp_q.delete();
                break;
            end
            w_ready   = (rdy_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            mw        = (in_ptr < 16) ? blk[511 - 32*in_ptr -: 32] : 32'h0;
            in_valid  = (in_ptr < 16) && (gap_cnt == 0);
            in_word   = mw;
            blk_start = start_pend || (start_on_done && expect_done);
            start_pend = 0;
            #1;
            checks++;
            if (done !== expect_done)
                begin errors++; $display("FAIL done_pulse: done=%b, required %b (cyc %0d)", done, expect_done, cyc); end
            checks++;
            if (busy !== !expect_done)
                begin errors++; $display("FAIL busy: busy=%b, required %b (cyc %0d)", busy, !expect_done, cyc); end
            if (expect_done) begin saw_done = 1; fin = 1; end
            if (w_valid && !w_ready) begin
                checks++;
                if (in_ready !== 1'b0)
                    begin errors++; $display("FAIL in_ready_stall: in_ready=%b, required 0", in_ready); end
            end
            if (prev_stall) begin
                checks++;
                if (w_valid !== 1'b1 || w_word !== prev_word || w_idx !== prev_idx)
                    begin errors++; $display("FAIL hold: valid=%b word=%h idx=%0d, required 1 %h %0d", w_valid, w_word, w_idx, prev_word, prev_idx); end
            end
            if (gap_cnt > 0 && w_valid) begin
                checks++;
                if (w_idx > 6'd4)
                    begin errors++; $display("FAIL gap_idx: w_idx=%0d during input gap, required <=4", w_idx); end
            end
            in_hs  = in_valid && in_ready;
            out_hs = w_valid && w_ready;
            expect_done = 0;
            if (out_hs) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL extra_word: idx=%0d word=%h, required none", w_idx, w_word);
                end else begin
                    e = exp_q.pop_front();
                    if ({w_idx, w_word} !== e)
                        begin errors++; $display("FAIL sched_word: idx=%0d word=%h, required idx=%0d word=%h", w_idx, w_word, e[37:32], e[31:0]); end
                end
                got_w[w_idx] = w_word;
                nwords++;
                if (w_idx == 6'd63) expect_done = 1;
                if (int'(w_idx) == start_at) start_pend = 1;
                if (int'(w_idx) == rst_at) rst_pend = 1;
            end
            if (in_hs) begin
                exp_q.push_back({6'(in_ptr), mw});
                in_ptr++;
                if (gap && in_ptr == 5) gap_cnt = 3;
                if (in_ptr == 16)
                    for (int t = 16; t < 64; t++) exp_q.push_back({6'(t), exp_w[t]});
            end else if (gap_cnt > 0) begin
                gap_cnt--;
            end
            prev_stall = w_valid && !w_ready;
            prev_word  = w_word;
            prev_idx   = w_idx;
            @(posedge CLK); #1;
            cyc++;
            if (cyc > 2000 && !fin) begin
                checks++; errors++;
                $display("FAIL timeout: %0d cycles without done, required done", cyc);
                fin = 1;
            end
        end
        blk_start = 1'b0;
        in_valid  = 1'b0;
        w_ready   = 1'b1;
        if (saw_done) begin
            #1;
            checks++;
            if (busy !== 1'b0 || w_valid !== 1'b0 || in_ready !== 1'b0)
                begin errors++; $display("FAIL idle_after_done: busy=%b w_valid=%b in_ready=%b, required 0", busy, w_valid, in_ready); end
            checks++;
            if (exp_q.size() != 0)
                begin errors++; $display("FAIL missing_words: %0d left, required 0", exp_q.size()); end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; blk_start = 1'b0; in_valid = 1'b0; in_word = 32'h0; w_ready = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: %b, required 0", in_ready); end
        checks++; if (w_valid !== 1'b0) begin errors++; $display("FAIL rst_w_valid: %b, required 0", w_valid); end
        checks++; if (w_word !== 32'h0) begin errors++; $display("FAIL rst_w_word: %h, required 0", w_word); end
        checks++; if (w_idx !== 6'd0) begin errors++; $display("FAIL rst_w_idx: %0d, required 0", w_idx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: %b, required 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: %b, required 0", done); end
        RST = 1'b0;
        in_valid = 1'b1;
        @(posedge CLK); #1;
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL idle_no_start: in_ready=%b busy=%b, required 0 0", in_ready, busy); end
        in_valid = 1'b0;
    endtask

    task automatic test_abc(input int rdy_mode, input string name);
        int n; bit d;
        run_block(ABC, rdy_mode, 1'b0, -1, -1, 1'b0, n, d);
        checks++; if (n != 64) begin errors++; $display("FAIL %s_count: %0d words, required 64", name, n); end
        checks++; if (d !== 1'b1) begin errors++; $display("FAIL %s_done: %b, required 1", name, d); end
        checks++; if (got_w[16] !== 32'h61626380) begin errors++; $display("FAIL %s_W16: %h, required 61626380", name, got_w[16]); end
        checks++; if (got_w[17] !== 32'h000F0000) begin errors++; $display("FAIL %s_W17: %h, required 000f0000", name, got_w[17]); end
        checks++; if (got_w[18] !== 32'h7DA86405) begin errors++; $display("FAIL %s_W18: %h, required 7da86405", name, got_w[18]); end
        checks++; if (got_w[63] !== 32'h12B1EDEB) begin errors++; $display("FAIL %s_W63: %h, required 12b1edeb", name, got_w[63]); end
    endtask

    task automatic test_input_gap();
        int n; bit d; logic [511:0] b;
        rand_block(b);
        run_block(b, 0, 1'b1, -1, -1, 1'b0, n, d);
        checks++; if (n != 64 || d !== 1'b1) begin errors++; $display("FAIL gap_block: %0d words done=%b, required 64 1", n, d); end
    endtask

    task automatic test_start_busy();
        int n; bit d; logic [511:0] b;
        rand_block(b);
        run_block(b, 1, 1'b0, 20, -1, 1'b0, n, d);
        checks++; if (n != 64 || d !== 1'b1) begin errors++; $display("FAIL start_busy: %0d words done=%b, required 64 1", n, d); end
    endtask

    task automatic test_start_on_done();
        int n; bit d; logic [511:0] b;
        rand_block(b);
        run_block(b, 0, 1'b0, -1, -1, 1'b1, n, d);
        checks++; if (n != 64 || d !== 1'b1) begin errors++; $display("FAIL start_on_done: %0d words done=%b, required 64 1", n, d); end
    endtask

    task automatic test_reset_mid();
        int n; bit d;
        run_block(ABC, 0, 1'b0, -1, 40, 1'b0, n, d);
        checks++; if (d !== 1'b0 || n != 41) begin errors++; $display("FAIL reset_mid: %0d words done=%b, required 41 0", n, d); end
        test_abc(0, "abc_after_rst");
    endtask

    task automatic test_back_to_back();
        int n; bit d; logic [511:0] b0, b1;
        rand_block(b0);
        rand_block(b1);
        run_block(b0, 0, 1'b0, -1, -1, 1'b0, n, d);
        run_block(b1, 1, 1'b0, -1, -1, 1'b0, n, d);
        checks++; if (n != 64 || d !== 1'b1) begin errors++; $display("FAIL b2b_second: %0d words done=%b, required 64 1", n, d); end
        checks++; if (got_w[0] !== b1[511:480]) begin errors++; $display("FAIL b2b_W0: %h, required %h", got_w[0], b1[511:480]); end
    endtask

    initial begin
        test_reset();
        test_abc(0, "abc");
        test_abc(1, "abc_bp");
        test_input_gap();
        test_start_busy();
        test_start_on_done();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
